// File: rtl/pcw_tick_timer.sv
// PCW 300 Hz tick timer: 13333/13333/13334 divider on the 4 MHz enable.
// Optional sticky overflow flag in data_out[7] when PCW_TIMER_OVF_EN is defined.
module pcw_tick_timer (
   input  logic       clk,
   input  logic       reset,
   input  logic       ce_4mhz,
   input  logic       rd_stb,
   input  logic       irq_mask,
   output logic       tick,
   output logic [3:0] pending,
   output logic [7:0] data_out,
   output logic       irq
);

   localparam logic [13:0] PER_SHORT = 14'd13333;
   localparam logic [13:0] PER_LONG  = 14'd13334;

   logic [13:0] div;
   logic [1:0]  phase;
   logic [1:0]  phase_nxt;
   logic [13:0] reload;
   logic        period_done;
   logic [3:0]  pending_nxt;
   logic        ovf;

   // Phase 2 carries the extra pulse so 3 ticks span exactly 40000 enables.
   always_comb begin
      phase_nxt   = (phase == 2'd2) ? 2'd0 : phase + 2'd1;
      reload      = (phase_nxt == 2'd2) ? PER_LONG : PER_SHORT;
      period_done = ce_4mhz && (div == 14'd1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div   <= PER_SHORT;
         phase <= 2'd0;
         tick  <= 1'b0;
      end else begin
         tick <= period_done;
         if (period_done) begin
            div   <= reload;
            phase <= phase_nxt;
         end else if (ce_4mhz) begin
            div <= div - 14'd1;
         end
      end
   end

   // A read clears the count, but a coincident tick still lands as 1.
   always_comb begin
      pending_nxt = pending;
      if (rd_stb) begin
         pending_nxt = {3'b000, tick};
      end else if (tick && (pending != 4'hF)) begin
         pending_nxt = pending + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= 4'd0;
         irq     <= 1'b0;
      end else begin
         pending <= pending_nxt;
         irq     <= (pending != 4'd0) & ~irq_mask;
      end
   end

`ifdef PCW_TIMER_OVF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf <= 1'b0;
      end else if (rd_stb) begin
         ovf <= 1'b0;
      end else if (tick && (pending == 4'hF)) begin
         ovf <= 1'b1;
      end
   end
`else
   assign ovf = 1'b0;
`endif

   assign data_out = {ovf, 3'b000, pending};

endmodule

// File: tb/tb_pcw_tick_timer.sv
// Directed bench for pcw_tick_timer: divider periods, read/clear,
// read-vs-tick collision, masking, saturation and mid-period reset.
module tb_pcw_tick_timer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ce_4mhz = 1'b0;
   logic       rd_stb = 1'b0;
   logic       irq_mask = 1'b0;
   logic       tick;
   logic [3:0] pending;
   logic [7:0] data_out;
   logic       irq;

   int compared = 0;
   int mismatched = 0;
   int n;

`ifdef PCW_TIMER_OVF_EN
   localparam logic [7:0] SAT_BYTE = 8'h8F;
`else
   localparam logic [7:0] SAT_BYTE = 8'h0F;
`endif

   always #5 clk = ~clk;

   pcw_tick_timer dut (
      .clk      (clk),
      .reset    (reset),
      .ce_4mhz  (ce_4mhz),
      .rd_stb   (rd_stb),
      .irq_mask (irq_mask),
      .tick     (tick),
      .pending  (pending),
      .data_out (data_out),
      .irq      (irq)
   );

   task automatic check(input string tag, input logic [15:0] obs,
                        input logic [15:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic c, input logic r);
      ce_4mhz = c;
      rd_stb  = r;
      @(posedge clk);
      #1;
      ce_4mhz = 1'b0;
      rd_stb  = 1'b0;
   endtask

   // Enables counted until tick shows; early enables optionally gapped.
   task automatic run_until_tick(input int gap_until, output int cnt);
      logic c;
      cnt = 0;
      for (int i = 0; i < 20000; i++) begin
         c = !((cnt < gap_until) && (i % 3 == 2));
         step(c, 1'b0);
         if (c) cnt++;
         if (tick) break;
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_tick", 16'(tick), 16'h0);
      check("rst_pending", 16'(pending), 16'h0);
      check("rst_data", 16'(data_out), 16'h00);
      check("rst_irq", 16'(irq), 16'h0);
      reset = 1'b0;

      run_until_tick(3000, n);
      check("period1", 16'(n), 16'd13333);
      step(1'b0, 1'b0);
      check("tick_width", 16'(tick), 16'h0);
      check("pend_after_t1", 16'(pending), 16'h1);
      check("irq_lag", 16'(irq), 16'h0);
      step(1'b0, 1'b0);
      check("irq_set", 16'(irq), 16'h1);

      run_until_tick(0, n);
      check("period2", 16'(n), 16'd13333);
      step(1'b0, 1'b0);
      check("pend_after_t2", 16'(pending), 16'h2);

      run_until_tick(0, n);
      check("period3", 16'(n), 16'd13334);
      step(1'b0, 1'b0);
      check("pend_after_t3", 16'(pending), 16'h3);
      check("read3_data", 16'(data_out), 16'h03);
      step(1'b0, 1'b1);
      check("read3_clear", 16'(pending), 16'h0);
      check("read3_irq_hold", 16'(irq), 16'h1);
      step(1'b0, 1'b0);
      check("read3_irq_drop", 16'(irq), 16'h0);
      step(1'b0, 1'b1);
      check("idle_rd_pend", 16'(pending), 16'h0);
      step(1'b0, 1'b0);
      check("idle_rd_irq", 16'(irq), 16'h0);

      force dut.pending = 4'd5;
      #1;
      release dut.pending;
      run_until_tick(0, n);
      check("period4_wrap", 16'(n), 16'd13333);
      check("coll_data", 16'(data_out), 16'h05);
      step(1'b0, 1'b1);
      check("coll_pend", 16'(pending), 16'h1);
      check("coll_data_after", 16'(data_out), 16'h01);
      check("coll_irq", 16'(irq), 16'h1);
      step(1'b0, 1'b0);
      check("coll_irq2", 16'(irq), 16'h1);

      force dut.pending = 4'd2;
      #1;
      release dut.pending;
      irq_mask = 1'b1;
      step(1'b0, 1'b0);
      check("mask_irq", 16'(irq), 16'h0);
      check("mask_pend", 16'(pending), 16'h2);
      irq_mask = 1'b0;
      step(1'b0, 1'b0);
      check("unmask_irq", 16'(irq), 16'h1);

      force dut.pending = 4'd15;
      #1;
      release dut.pending;
      run_until_tick(0, n);
      check("period5", 16'(n), 16'd13333);
      step(1'b0, 1'b0);
      check("sat_pend", 16'(pending), 16'hF);
      check("sat_data", 16'(data_out), 16'(SAT_BYTE));
      step(1'b0, 1'b1);
      check("sat_read_data", 16'(data_out), 16'h00);

      force dut.pending = 4'd7;
      #1;
      release dut.pending;
      for (int i = 0; i < 100; i++) step(1'b1, 1'b0);
      reset = 1'b1;
      #1;
      check("mid_rst_pend", 16'(pending), 16'h0);
      check("mid_rst_data", 16'(data_out), 16'h00);
      check("mid_rst_irq", 16'(irq), 16'h0);
      check("mid_rst_tick", 16'(tick), 16'h0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      run_until_tick(0, n);
      check("post_rst_period", 16'(n), 16'd13333);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
